// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the pipeline-boundary skid register: occupancy states
// and the per-cycle register load controls produced by the FSM.
package pipe_skid_reg_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic clear;          // flush: both payload regs return to RESET_VAL
    logic load_main_in;   // main <= in_data
    logic load_main_skid; // main <= skid (drain of the second entry)
    logic load_skid;      // skid <= in_data (downstream stalled while ONE)
  } ctrl_t;

endpackage

// File: rtl/pipe_skid_reg_stall_cnt.sv
// Saturating performance counter: counts qualifying cycles, never wraps,
// cleared only by reset.
module pipe_skid_reg_stall_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-boundary register with a 2-entry skid buffer, flush and a
// saturating stall counter. in_ready and out_valid come straight from flops.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int              DATA_W    = 108,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int              CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output state_e            dbg_state
);

  // Handshake: a beat moves on a port in any cycle where valid and ready are
  // both high at the rising edge. A producer holding valid keeps its data
  // stable until ready; in_ready is a pure function of registered occupancy,
  // so out_ready never reaches in_ready combinationally.

  state_e            state_q, state_d;
  ctrl_t             ctrl;
  logic              in_ready_q, out_valid_q;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    if (flush) begin
      // A concurrent in_fire is dropped; a concurrent out_fire already left.
      state_d    = ST_EMPTY;
      ctrl.clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            ctrl.load_main_in = 1'b1;
            state_d           = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            ctrl.load_main_in = 1'b1;
          end else if (in_fire) begin
            ctrl.load_skid = 1'b1;
            state_d        = ST_TWO;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            ctrl.load_main_skid = 1'b1;
            state_d             = ST_ONE;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          ctrl.clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ctrl.clear) begin
      main_q <= RESET_VAL;
    end else if (ctrl.load_main_in) begin
      main_q <= in_data;
    end else if (ctrl.load_main_skid) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ctrl.clear) begin
      skid_q <= RESET_VAL;
    end else if (ctrl.load_skid) begin
      skid_q <= in_data;
    end
  end

  pipe_skid_reg_stall_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid_q & ~out_ready & ~flush),
    .cnt (stall_cnt)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign dbg_state = state_q;

endmodule
